ahb_instr_sequencer: RTL and testbench

Program sequencer for the AHB master. It owns the 10-bit program counter and reads 23-bit instructions from the instruction memory, whose read is combinational on `pc`. Each instruction is issued as one AHB single transfer on the slave bus, and read data is returned to the system. It sits directly downstream of the instruction memory and directly upstream of the AHB slaves.

---
 rtl/ahb_seq_pkg.sv | 55 +++++
 rtl/ahb_instr_sequencer.sv | 160 ++++++++++++++++
 tb/tb_ahb_instr_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_seq_pkg.sv
// ---------------------------------------------------------------------------
// ahb_seq_pkg
//   Shared definitions for the AHB program sequencer:
//     - AHB HTRANS encodings used by the sequencer (IDLE, NONSEQ)
//     - sequencer FSM state enumeration
//     - instruction word layout (bit positions / widths) and a decode
//       function that splits a raw instruction word into its fields
// ---------------------------------------------------------------------------
package ahb_seq_pkg;

  // AHB transfer types driven on HTRANS
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_e;

  // Instruction word layout: [22] write, [21:19] burst, [18] sel,
  // [17:8] addr, [7:0] data
  localparam int INSTR_BITS = 23;
  localparam int WRITE_POS  = 22;
  localparam int BURST_LSB  = 19;
  localparam int BURST_W    = 3;
  localparam int SEL_POS    = 18;
  localparam int ADDR_LSB   = 8;
  localparam int ADDR_W     = 10;
  localparam int DATA_LSB   = 0;
  localparam int DATA_W     = 8;

  typedef struct packed {
    logic               write;
    logic [BURST_W-1:0] burst;
    logic               sel;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
  } instr_t;

  // Split a raw instruction word into named fields.
  function automatic instr_t decode_instr(input logic [INSTR_BITS-1:0] raw);
    instr_t f;
    f.write = raw[WRITE_POS];
    f.burst = raw[BURST_LSB +: BURST_W];
    f.sel   = raw[SEL_POS];
    f.addr  = raw[ADDR_LSB +: ADDR_W];
    f.data  = raw[DATA_LSB +: DATA_W];
    return f;
  endfunction

endpackage

// File: rtl/ahb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// ahb_instr_sequencer
//   Program sequencer for an AHB master. Walks the program counter over
//   addresses 0..PROG_LEN-1 of a combinational instruction memory and issues
//   each instruction as one AHB single transfer (FETCH -> ADDR -> DATA).
//   Read data is returned on rdata with a one-cycle rdata_valid pulse.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   start               : start a run (honoured only in IDLE or DONE)
//   pc                  : address to the instruction memory
//   instruction         : instruction word read combinationally at pc
//   HSEL/HADDR/HWRITE/
//   HBURST/HTRANS       : AHB address-phase controls
//   HWDATA              : AHB write data (data phase of writes)
//   HREADY/HRESP/HRDATA : AHB slave response
//   rdata/rdata_valid   : captured read data and its one-cycle strobe
//   busy/done/error     : run status
// ---------------------------------------------------------------------------
module ahb_instr_sequencer
  import ahb_seq_pkg::*;
#(
  parameter int PC_W     = 10,
  parameter int INSTR_W  = 23,
  parameter int PROG_LEN = 36
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instruction,
  output logic               HSEL,
  output logic [ADDR_W-1:0]  HADDR,
  output logic               HWRITE,
  output logic [BURST_W-1:0] HBURST,
  output logic [1:0]         HTRANS,
  output logic [DATA_W-1:0]  HWDATA,
  input  logic               HREADY,
  input  logic               HRESP,
  input  logic [DATA_W-1:0]  HRDATA,
  output logic [DATA_W-1:0]  rdata,
  output logic               rdata_valid,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rdata_valid_q, rdata_valid_d;
  logic                error_q, error_d;

  instr_t              fields;
  logic                in_addr;
  logic                in_data;

  assign fields  = decode_instr(instr_q);
  assign in_addr = (state_q == ST_ADDR);
  assign in_data = (state_q == ST_DATA);

  // Next-state and datapath logic.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    error_d       = error_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          error_d = 1'b0;
        end
      end

      ST_FETCH: begin
        instr_d = instruction;
        state_d = ST_ADDR;
      end

      ST_ADDR: begin
        if (HREADY) state_d = ST_DATA;
      end

      ST_DATA: begin
        // HREADY low stretches the data phase with all state held.
        if (HREADY) begin
          if (HRESP) begin
            // Error response: stop with pc on the failing instruction and
            // drop the read data.
            state_d = ST_DONE;
            error_d = 1'b1;
          end else begin
            if (!fields.write) begin
              rdata_d       = HRDATA;
              rdata_valid_d = 1'b1;
            end
            // pc stops at the last instruction, so it never wraps.
            if (pc_q == LAST_PC) begin
              state_d = ST_DONE;
            end else begin
              pc_d    = pc_q + 1'b1;
              state_d = ST_FETCH;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  // NOTE: reset is synchronous; it only takes effect on a rising clk edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      error_q       <= error_d;
    end
  end

  // Bus outputs decode only registered state and instr_q, so nothing from
  // HREADY reaches the address phase combinationally. Every transfer is a
  // single NONSEQ; HBURST is passed through without affecting sequencing.
  assign HTRANS = in_addr ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HSEL   = in_addr & fields.sel;
  assign HADDR  = in_addr ? fields.addr  : '0;
  assign HWRITE = in_addr & fields.write;
  assign HBURST = in_addr ? fields.burst : '0;
  assign HWDATA = (in_data && fields.write) ? fields.data : '0;

  assign pc          = pc_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign error       = error_q;
  assign busy        = (state_q == ST_FETCH) || in_addr || in_data;
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_ahb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ahb_instr_sequencer
//   Directed bench for ahb_instr_sequencer. A 36-entry program of
//   write/read pairs sits in a combinational instruction memory model.
//   Instruction i: write = (i even), burst = i % 8, sel = write,
//   addr = i/2 + 1, data = i/2 + 1 for writes and 0 for reads.
//   A second instance with PROG_LEN = 1 shares the same memory.
// ---------------------------------------------------------------------------
module tb_ahb_instr_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start1;
  logic        HREADY;
  logic        HRESP;
  logic [7:0]  HRDATA;

  logic [22:0] prog [36];

  // Main instance (PROG_LEN = 36)
  logic [9:0]  pc;
  logic [22:0] instruction;
  logic        HSEL, HWRITE;
  logic [9:0]  HADDR;
  logic [2:0]  HBURST;
  logic [1:0]  HTRANS;
  logic [7:0]  HWDATA;
  logic [7:0]  rdata;
  logic        rdata_valid, busy, done, error;

  // Single-instruction instance (PROG_LEN = 1)
  logic [9:0]  pc1;
  logic [22:0] instruction1;
  logic        hsel1, hwrite1;
  logic [9:0]  haddr1;
  logic [2:0]  hburst1;
  logic [1:0]  htrans1;
  logic [7:0]  hwdata1;
  logic [7:0]  rdata1;
  logic        rdata_valid1, busy1, done1, error1;

  int errors = 0;
  int checks = 0;

  int busy_cnt = 0;
  int pc2_cnt  = 0;
  int ns1_cnt  = 0;
  int base;

  assign instruction  = (pc  < 10'd36) ? prog[pc]  : 23'd0;
  assign instruction1 = (pc1 < 10'd36) ? prog[pc1] : 23'd0;

  ahb_instr_sequencer #(.PC_W(10), .INSTR_W(23), .PROG_LEN(36)) u_dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .instruction(instruction),
    .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HBURST(HBURST),
    .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
    .HRDATA(HRDATA), .rdata(rdata), .rdata_valid(rdata_valid),
    .busy(busy), .done(done), .error(error)
  );

  ahb_instr_sequencer #(.PC_W(10), .INSTR_W(23), .PROG_LEN(1)) u_one (
    .clk(clk), .rst(rst), .start(start1), .pc(pc1), .instruction(instruction1),
    .HSEL(hsel1), .HADDR(haddr1), .HWRITE(hwrite1), .HBURST(hburst1),
    .HTRANS(htrans1), .HWDATA(hwdata1), .HREADY(HREADY), .HRESP(HRESP),
    .HRDATA(HRDATA), .rdata(rdata1), .rdata_valid(rdata_valid1),
    .busy(busy1), .done(done1), .error(error1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (busy && pc == 10'd2) pc2_cnt++;
    if (htrans1 == 2'b10) ns1_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // Advance until the main DUT shows the address phase of instruction
  // 'target'; an expired budget is reported as a failed comparison.
  task automatic wait_addr(input logic [9:0] target, input string tag);
    int n = 0;
    while (!(pc == target && HTRANS == 2'b10) && n < 400) begin
      tick();
      n++;
    end
    check(tag, 32'(pc == target && HTRANS == 2'b10), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 36; i++) begin
      logic       w;
      logic [7:0] v;
      w = (i % 2 == 0);
      v = 8'(i / 2 + 1);
      prog[i] = {w, 3'(i % 8), w, 10'(i / 2 + 1), (w ? v : 8'h00)};
    end

    rst    = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 8'h01;
    tick();
    tick();
    rst = 1'b0;

    // ---- Reset state
    check("rst_htrans", 32'(HTRANS), 32'h0);
    check("rst_pc",     32'(pc), 0);
    check("rst_busy",   32'(busy), 0);
    check("rst_done",   32'(done), 0);
    check("rst_error",  32'(error), 0);
    check("rst_rvalid", 32'(rdata_valid), 0);
    check("rst_rdata",  32'(rdata), 0);
    check("rst_hsel",   32'(HSEL), 0);
    check("rst_haddr",  32'(HADDR), 0);
    check("rst_hwdata", 32'(HWDATA), 0);

    // ---- Run 1: zero wait states over the whole program
    base  = busy_cnt;
    start = 1'b1;
    tick();                               // FETCH instr 0
    start = 1'b0;
    check("r1_fetch_busy",   32'(busy), 1);
    check("r1_fetch_htrans", 32'(HTRANS), 32'h0);
    check("r1_fetch_pc",     32'(pc), 0);
    tick();                               // ADDR instr 0
    check("i0_htrans", 32'(HTRANS), 32'h2);
    check("i0_hwrite", 32'(HWRITE), 1);
    check("i0_hsel",   32'(HSEL), 1);
    check("i0_haddr",  32'(HADDR), 1);
    check("i0_hburst", 32'(HBURST), 0);
    tick();                               // DATA instr 0
    check("i0_data_htrans", 32'(HTRANS), 32'h0);
    check("i0_data_hsel",   32'(HSEL), 0);
    check("i0_hwdata",      32'(HWDATA), 32'h01);
    tick();                               // FETCH instr 1
    check("i1_fetch_pc", 32'(pc), 1);
    tick();                               // ADDR instr 1 (read of address 1)
    check("i1_hwrite", 32'(HWRITE), 0);
    check("i1_haddr",  32'(HADDR), 1);
    check("i1_hsel",   32'(HSEL), 0);
    start = 1'b1;                         // pulse while busy: ignored
    tick();                               // DATA instr 1
    start = 1'b0;
    check("busy_start_pc",     32'(pc), 1);
    check("busy_start_htrans", 32'(HTRANS), 32'h0);
    check("i1_hwdata",         32'(HWDATA), 32'h0);
    check("i1_rvalid_early",   32'(rdata_valid), 0);
    tick();                               // FETCH instr 2
    check("i1_rdata",  32'(rdata), 32'h01);
    check("i1_rvalid", 32'(rdata_valid), 1);
    check("i2_pc",     32'(pc), 2);
    tick();                               // ADDR instr 2
    check("i1_rvalid_pulse", 32'(rdata_valid), 0);

    wait_addr(10'd35, "r1_reach_last");
    tick();                               // DATA of final instruction
    start = 1'b1;                         // start with final HREADY: ignored
    tick();                               // DONE
    start = 1'b0;
    check("r1_done",   32'(done), 1);
    check("r1_busy",   32'(busy), 0);
    check("r1_pc",     32'(pc), 35);
    check("r1_error",  32'(error), 0);
    tick();
    check("r1_done_hold",  32'(done), 1);
    check("r1_busy_hold",  32'(busy), 0);
    check("r1_busy_count", 32'(busy_cnt - base), 108);

    // ---- Run 2: wait states on instr 2, then error on instr 5
    HRDATA = 8'h3C;
    base   = pc2_cnt;
    start  = 1'b1;
    tick();                               // FETCH instr 0
    start  = 1'b0;
    check("r2_restart_pc",   32'(pc), 0);
    check("r2_restart_done", 32'(done), 0);
    wait_addr(10'd2, "r2_reach_i2");
    check("i2_hburst", 32'(HBURST), 2);
    check("i2_haddr",  32'(HADDR), 2);
    check("i2_hwrite", 32'(HWRITE), 1);
    tick();                               // DATA instr 2
    HREADY = 1'b0;
    check("i2_hwdata_first", 32'(HWDATA), 32'h02);
    for (int w = 0; w < 3; w++) begin
      tick();                             // stretched data phase
      check($sformatf("i2_wait%0d_hwdata", w), 32'(HWDATA), 32'h02);
      check($sformatf("i2_wait%0d_pc", w),     32'(pc), 2);
      check($sformatf("i2_wait%0d_htrans", w), 32'(HTRANS), 32'h0);
    end
    HREADY = 1'b1;
    tick();                               // FETCH instr 3
    check("i3_pc",        32'(pc), 3);
    check("i2_cycle_cnt", 32'(pc2_cnt - base), 6);

    wait_addr(10'd5, "r2_reach_i5");
    HRDATA = 8'hEE;
    tick();                               // DATA instr 5
    HRESP = 1'b1;
    tick();                               // error response -> DONE
    HRESP = 1'b0;
    check("err_done",   32'(done), 1);
    check("err_error",  32'(error), 1);
    check("err_pc",     32'(pc), 5);
    check("err_busy",   32'(busy), 0);
    check("err_rvalid", 32'(rdata_valid), 0);
    check("err_rdata",  32'(rdata), 32'h3C);
    tick();
    check("err_rvalid_late", 32'(rdata_valid), 0);
    check("err_hold",        32'(error), 1);

    // ---- Run 3: start from DONE clears error; reset mid-DATA at instr 7
    start = 1'b1;
    tick();
    start = 1'b0;
    check("r3_pc",    32'(pc), 0);
    check("r3_error", 32'(error), 0);
    check("r3_busy",  32'(busy), 1);
    wait_addr(10'd7, "r3_reach_i7");
    tick();                               // DATA instr 7
    HREADY = 1'b0;
    tick();                               // still DATA
    check("i7_in_data", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    HREADY = 1'b1;
    check("mrst_htrans", 32'(HTRANS), 32'h0);
    check("mrst_pc",     32'(pc), 0);
    check("mrst_busy",   32'(busy), 0);
    check("mrst_done",   32'(done), 0);
    check("mrst_error",  32'(error), 0);
    check("mrst_rdata",  32'(rdata), 0);
    check("mrst_rvalid", 32'(rdata_valid), 0);
    check("mrst_hwdata", 32'(HWDATA), 0);
    check("mrst_haddr",  32'(HADDR), 0);
    tick();
    check("mrst_no_retry", 32'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("r4_pc", 32'(pc), 0);
    tick();
    check("r4_htrans", 32'(HTRANS), 32'h2);
    check("r4_haddr",  32'(HADDR), 1);
    check("r4_hwrite", 32'(HWRITE), 1);

    // ---- PROG_LEN = 1 instance: exactly one transfer
    base   = ns1_cnt;
    start1 = 1'b1;
    tick();                               // FETCH
    start1 = 1'b0;
    check("one_busy", 32'(busy1), 1);
    tick();                               // ADDR
    check("one_htrans", 32'(htrans1), 32'h2);
    check("one_haddr",  32'(haddr1), 1);
    tick();                               // DATA
    check("one_hwdata", 32'(hwdata1), 32'h01);
    tick();                               // DONE
    check("one_done", 32'(done1), 1);
    check("one_pc",   32'(pc1), 0);
    check("one_busy_end", 32'(busy1), 0);
    tick();
    tick();
    check("one_transfers", 32'(ns1_cnt - base), 1);
    check("one_done_hold", 32'(done1), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
